spi_mem_responder: RTL
======================

// Module: spi_mem_responder
// PURPOSE
//  SPI mode-0 target emulating a serial flash/SRAM; the responder side of the mem_read fetch path.
//  Oversamples sclk/cs/mosi in the system clock domain and decodes READ (0x03) and WRITE (0x02) commands with a 24-bit address.
//  Serves bytes from a 1-cycle-latency byte memory port, MSB first.
//  Used as the bench memory model and as an on-chip scratch-memory target.
// PARAMETERS
//  ADDR_W       24     memory address width; the low ADDR_W bits of the 24-bit SPI address are kept
//  SYNC_STAGES  2      synchronizer flops on sclk, cs, mosi (>=1)
//  READ_CMD     8'h03  opcode for read with address auto-increment
//  WRITE_CMD    8'h02  opcode for write with address auto-increment
// PORTS
//  clk        in   1       system clock; all logic on posedge
//  rst_n      in   1       synchronous reset, active low
//  sclk       in   1       SPI clock from the initiator; idle low
//  cs         in   1       SPI chip select, active low
//  mosi       in   1       SPI data from the initiator
//  miso       out  1       SPI data to the initiator; driven 0 when not sending data
//  mem_addr   out  ADDR_W  byte address for the current memory access
//  mem_rd     out  1       1-cycle read strobe; mem_rdata is valid the cycle after
//  mem_rdata  in   8       read data
//  mem_we     out  1       1-cycle write strobe with mem_addr/mem_wdata
//  mem_wdata  out  8       write data
//  busy       out  1       1 while a transaction is active (state != IDLE)
// BEHAVIOUR
//  - Reset: every output is 0, state is IDLE, and the shift registers and counters are cleared. The synchronizers reset to sclk=0, cs=1, mosi=0.
//  - Edges are detected on the synchronized sclk (s vs its registered copy). rise = s & ~q; fall = ~s & q.
//  - Edges are ignored while synchronized cs=1. A synchronized cs=1 in any state returns the FSM to IDLE in the next cycle and drives miso=0.
//  - Any partially shifted byte is discarded on cs=1; a partial write byte is never written.
//  - On rise: rx_sr <= {rx_sr[6:0], mosi}; bit_cnt increments modulo 8.
//  - On fall (READ_DATA only): miso <= tx_sr[7]; tx_sr <= tx_sr << 1.
//  - The initiator shifts mosi on falls and samples miso on rises.
//  - FSM:
//    - IDLE: on cs falling, go to CMD and clear bit_cnt.
//    - CMD: after the 8th rise, go to ADDR if rx_sr==READ_CMD or WRITE_CMD; otherwise go to IGNORE.
//    - ADDR: shift 24 bits MSB first. After the 24th rise, latch the address (low ADDR_W bits) into mem_addr.
//      For READ, pulse mem_rd the next cycle and go to READ_DATA. For WRITE, go to WRITE_DATA.
//    - READ_DATA:
//      - mem_rdata is captured into nxt_byte 1 cycle after mem_rd.
//      - At the first fall after byte-boundary (bit_cnt==0) rises: miso <= nxt_byte[7], tx_sr <= nxt_byte<<1.
//      - After the 8th rise of each data byte, mem_addr increments and mem_rd pulses (prefetch).
//      - One extra prefetch past the last clocked byte is legal; reads have no side effects.
//    - WRITE_DATA: after each 8th rise, mem_wdata <= byte and mem_we pulses 1 cycle at the current mem_addr. mem_addr increments the cycle after.
//    - IGNORE: miso=0, no memory strobes, until cs=1.
//  - Before the first data fall (CMD, ADDR, IGNORE) miso=0.
//  - mem_addr wraps modulo 2^ADDR_W (0xFFFFFF -> 0x000000).
//  - Timing requirement: each sclk half-period must be at least SYNC_STAGES+4 clk cycles, so the prefetch lands before the next fall.
//    The mem_read initiator (sclk = clk/16, half-period 8) meets this with SYNC_STAGES=2.
//  - rst_n low mid-transaction: the block returns to reset values in the next cycle.
//    Remaining edges of that cs-low window are ignored until cs returns high.
//  - mem_rd and mem_we are never asserted in the same cycle.
// TESTING
//  1 Mem[0x10..0x13]=DE,AD,BE,EF; mem_read fetches 0x000010 -> fetched_data=0xDEADBEEF.
//    mem_rd pulses at 0x10,0x11,0x12,0x13 (plus an optional 0x14 prefetch); busy drops after cs rises.
//  2 Read at 0xFFFFFE with mem[FFFFFE]=01, [FFFFFF]=02, [000000]=03, [000001]=04 -> data 0x01020304; mem_addr wraps to 0.
//  3 Write: 02 00 01 00 11 22 then cs high -> exactly 2 mem_we pulses: (0x100,0x11) and (0x101,0x22); no mem_rd.
//  4 Write: 02 00 01 00 11 then 5 bits of a second byte, then cs high -> only (0x100,0x11) is written; busy returns to 0.
//  5 Opcode 0x9F followed by 56 clocks -> no mem_rd/mem_we; miso stays 0 throughout.
//  6 cs high after 12 address bits, then a new read of 0x000010 -> result 0xDEADBEEF.
//    rst_n pulsed mid-READ_DATA -> all outputs 0 next cycle, and the next transaction succeeds.

Source files
------------

// File: rtl/spi_mem_responder_if.sv
// ============================================================================
// Module  : spi_mem_responder_if
// Brief   : SPI pins and byte-memory port of the SPI memory responder.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface spi_mem_responder_if #(
    parameter int ADDR_W = 24
);
    logic              sclk;
    logic              cs;
    logic              mosi;
    logic              miso;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic [7:0]        mem_rdata;
    logic              mem_we;
    logic [7:0]        mem_wdata;
    logic              busy;

    // slave: the responder; master: the SPI initiator plus the backing memory
    modport slave (
        input  sclk, cs, mosi, mem_rdata,
        output miso, mem_addr, mem_rd, mem_we, mem_wdata, busy
    );

    modport master (
        output sclk, cs, mosi, mem_rdata,
        input  miso, mem_addr, mem_rd, mem_we, mem_wdata, busy
    );
endinterface

`default_nettype wire

// File: rtl/spi_mem_responder.sv
// ============================================================================
// Module  : spi_mem_responder
// Brief   : SPI mode-0 flash/SRAM-style target, READ/WRITE with 24-bit address.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_mem_responder #(
    parameter int         ADDR_W      = 24,
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] READ_CMD    = 8'h03,
    parameter logic [7:0] WRITE_CMD   = 8'h02
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    spi_mem_responder_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CMD    = 3'd1,
        S_ADDR   = 3'd2,
        S_READ   = 3'd3,
        S_WRITE  = 3'd4,
        S_IGNORE = 3'd5
    } state_e;

    localparam logic [ADDR_W-1:0] C_ADDR_ONE = 1;

    state_e                 state_q, state_d;

    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic [SYNC_STAGES-1:0] vld_q;
    logic                   sclk_prev_q;
    logic                   cs_prev_q;

    logic                   sclk_s, cs_s, mosi_s;
    logic                   rise, fall, cs_fall, byte_done;
    logic [7:0]             rx_byte;
    logic [23:0]            addr_full;

    logic [7:0]             rx_sr_q, rx_sr_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [1:0]             byte_cnt_q, byte_cnt_d;
    logic [23:0]            addr_sr_q, addr_sr_d;
    logic                   is_read_q, is_read_d;
    logic [7:0]             tx_sr_q, tx_sr_d;
    logic [7:0]             nxt_byte_q, nxt_byte_d;
    logic                   load_q, load_d;
    logic                   cap_q;
    logic                   miso_q, miso_d;
    logic [ADDR_W-1:0]      mem_addr_q, mem_addr_d;
    logic                   mem_rd_q, mem_rd_d;
    logic                   mem_we_q, mem_we_d;
    logic [7:0]             mem_wdata_q, mem_wdata_d;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign rise      = sclk_s & ~sclk_prev_q & ~cs_s;
    assign fall      = ~sclk_s & sclk_prev_q & ~cs_s;
    // cs_prev_q only goes high once the synchronizer holds real samples, so a
    // cs-low window already in progress at reset release is never decoded.
    assign cs_fall   = ~cs_s & cs_prev_q;
    assign byte_done = rise & (bit_cnt_q == 3'd7);
    assign rx_byte   = {rx_sr_q[6:0], mosi_s};
    assign addr_full = {addr_sr_q[22:0], mosi_s};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            vld_q       <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b0;
            rx_sr_q     <= '0;
            bit_cnt_q   <= '0;
            byte_cnt_q  <= '0;
            addr_sr_q   <= '0;
            is_read_q   <= 1'b0;
            tx_sr_q     <= '0;
            nxt_byte_q  <= '0;
            load_q      <= 1'b0;
            cap_q       <= 1'b0;
            miso_q      <= 1'b0;
            mem_addr_q  <= '0;
            mem_rd_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
        end else begin
            state_q        <= state_d;
            sclk_sync_q[0] <= bus.sclk;
            cs_sync_q[0]   <= bus.cs;
            mosi_sync_q[0] <= bus.mosi;
            vld_q[0]       <= 1'b1;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sclk_sync_q[i] <= sclk_sync_q[i-1];
                cs_sync_q[i]   <= cs_sync_q[i-1];
                mosi_sync_q[i] <= mosi_sync_q[i-1];
                vld_q[i]       <= vld_q[i-1];
            end
            sclk_prev_q <= sclk_s;
            cs_prev_q   <= cs_s & vld_q[SYNC_STAGES-1];
            rx_sr_q     <= rx_sr_d;
            bit_cnt_q   <= bit_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            addr_sr_q   <= addr_sr_d;
            is_read_q   <= is_read_d;
            tx_sr_q     <= tx_sr_d;
            nxt_byte_q  <= nxt_byte_d;
            load_q      <= load_d;
            cap_q       <= mem_rd_q;
            miso_q      <= miso_d;
            mem_addr_q  <= mem_addr_d;
            mem_rd_q    <= mem_rd_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rx_sr_d     = rx_sr_q;
        bit_cnt_d   = bit_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        addr_sr_d   = addr_sr_q;
        is_read_d   = is_read_q;
        tx_sr_d     = tx_sr_q;
        nxt_byte_d  = cap_q ? bus.mem_rdata : nxt_byte_q;
        load_d      = load_q;
        miso_d      = miso_q;
        // a write strobe is followed by the address step in the next cycle
        mem_addr_d  = mem_we_q ? mem_addr_q + C_ADDR_ONE : mem_addr_q;
        mem_rd_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_wdata_d = mem_wdata_q;

        if (cs_s) begin
            state_d    = S_IDLE;
            miso_d     = 1'b0;
            load_d     = 1'b0;
            rx_sr_d    = '0;
            bit_cnt_d  = '0;
            byte_cnt_d = '0;
        end else begin
            if (rise) begin
                rx_sr_d   = rx_byte;
                bit_cnt_d = bit_cnt_q + 3'd1;
            end

            unique case (state_q)
                S_IDLE: begin
                    if (cs_fall) begin
                        state_d    = S_CMD;
                        rx_sr_d    = '0;
                        bit_cnt_d  = '0;
                        byte_cnt_d = '0;
                    end
                end
                S_CMD: begin
                    if (byte_done) begin
                        byte_cnt_d = '0;
                        if (rx_byte == READ_CMD || rx_byte == WRITE_CMD) begin
                            state_d   = S_ADDR;
                            is_read_d = (rx_byte == READ_CMD);
                        end else begin
                            state_d = S_IGNORE;
                        end
                    end
                end
                S_ADDR: begin
                    if (rise) begin
                        addr_sr_d = addr_full;
                        if (bit_cnt_q == 3'd7) begin
                            byte_cnt_d = byte_cnt_q + 2'd1;
                            if (byte_cnt_q == 2'd2) begin
                                mem_addr_d = addr_full[ADDR_W-1:0];
                                if (is_read_q) begin
                                    state_d  = S_READ;
                                    mem_rd_d = 1'b1;
                                    load_d   = 1'b1;
                                end else begin
                                    state_d = S_WRITE;
                                end
                            end
                        end
                    end
                end
                S_READ: begin
                    if (fall) begin
                        if (load_q) begin
                            miso_d  = nxt_byte_q[7];
                            tx_sr_d = {nxt_byte_q[6:0], 1'b0};
                            load_d  = 1'b0;
                        end else begin
                            miso_d  = tx_sr_q[7];
                            tx_sr_d = {tx_sr_q[6:0], 1'b0};
                        end
                    end
                    // prefetch the next byte; it lands well before the next fall
                    if (byte_done) begin
                        mem_addr_d = mem_addr_q + C_ADDR_ONE;
                        mem_rd_d   = 1'b1;
                        load_d     = 1'b1;
                    end
                end
                S_WRITE: begin
                    if (byte_done) begin
                        mem_wdata_d = rx_byte;
                        mem_we_d    = 1'b1;
                    end
                end
                S_IGNORE: begin
                    miso_d = 1'b0;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign bus.miso      = miso_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_rd    = mem_rd_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.busy      = (state_q != S_IDLE);

endmodule

`default_nettype wire
